// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : 8N1 UART transmitter fed by a circular byte FIFO through an
//            Avalon-ST sink, with clear-to-send flow control.
// Ports    : clk        - sole clock, rising edge
//            reset_n    - asynchronous active-low reset
//            in_valid   - sink valid
//            in_data    - byte to transmit
//            in_ready   - sink ready (FIFO not full)
//            uart_cts   - asynchronous clear-to-send, high permits a new frame
//            uart_txd   - registered serial output, idle high
//            busy       - frame on the line or FIFO non-empty
//            fifo_level - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int unsigned CLOCK_FREQ      = 50000000,
  parameter int unsigned BAUDRATE        = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic                       uart_cts,
  output logic                       uart_txd,
  output logic                       busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  // Rounded-to-nearest clocks per bit.
  localparam int unsigned DIVIDER = (CLOCK_FREQ + BAUDRATE / 2) / BAUDRATE;
  localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIVIDER - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE     = LVL_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [7:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic              cts_meta_q, cts_s_q;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [7:0]        rd_data;
  logic              can_start;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  assign in_ready   = (level_q < LVL_FULL);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level_q == '0);
  assign rd_data    = mem_q[rptr_q];

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register (FSM, datapath, FIFO pointers, CTS synchroniser)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      cts_meta_q <= uart_cts;
      cts_s_q    <= cts_meta_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  // CTS is only consulted at a frame boundary, so a mid-frame drop cannot
  // affect the frame already on the line.
  assign can_start = ~fifo_empty & cts_s_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          shift_d = rd_data;
          bit_d   = '0;
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          // Chain straight into the next start bit when a byte is waiting.
          if (can_start) begin
            pop     = 1'b1;
            shift_d = rd_data;
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: the line level is derived from the upcoming state so that
  // the registered pin changes on the same edge as the state transition.
  // --------------------------------------------------------------------------
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign uart_txd   = txd_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_level = level_q;

endmodule
`default_nettype wire
